// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 8x8 multiplier.
// Holds the FSM state encoding and the operand/product/counter widths used
// by the multiplier top level and its assertion checker.
package mult_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/CLA_16_bit_lookahead.sv
// 16-bit two-level carry-lookahead adder.
// Ports:
//   a, b  : 16-bit addends
//   cin   : carry in
//   sum   : 16-bit sum
//   cout  : carry out of bit 15
// Four 4-bit groups each form group generate/propagate; group carries are
// then produced in parallel from those terms and cin.
module CLA_16_bit_lookahead (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] p_s;
    logic [15:0] g_s;
    logic [3:0]  gg_s;
    logic [3:0]  gp_s;
    logic [4:0]  cg_s;
    logic [16:0] c_s;

    assign p_s = a ^ b;
    assign g_s = a & b;

    // Group generate / propagate for each 4-bit slice.
    always_comb begin
        gg_s = 4'h0;
        gp_s = 4'h0;
        for (int k = 0; k < 4; k++) begin
            gg_s[k] = g_s[4*k+3]
                    | (p_s[4*k+3] & g_s[4*k+2])
                    | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                    | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
            gp_s[k] = &p_s[4*k +: 4];
        end
    end

    // Second-level lookahead: all group carries are flat sums of products.
    always_comb begin
        cg_s    = 5'h00;
        cg_s[0] = cin;
        cg_s[1] = gg_s[0] | (gp_s[0] & cin);
        cg_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & cin);
        cg_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
                | (gp_s[2] & gp_s[1] & gp_s[0] & cin);
        cg_s[4] = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
                | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0])
                | (gp_s[3] & gp_s[2] & gp_s[1] & gp_s[0] & cin);
    end

    // Bit carries inside each group, driven from the group carry-in.
    always_comb begin
        c_s = 17'h00000;
        for (int k = 0; k < 4; k++) begin
            c_s[4*k]   = cg_s[k];
            c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & cg_s[k]);
            c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                       | (p_s[4*k+1] & p_s[4*k] & cg_s[k]);
            c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                       | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                       | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & cg_s[k]);
        end
        c_s[16] = cg_s[4];
    end

    assign sum  = p_s ^ c_s[15:0];
    assign cout = c_s[16];

endmodule

// File: rtl/seq_mult_8x8_cla_chk.sv
// Assertion checker for seq_mult_8x8_cla.
// Ports:
//   clk, rst : clock and synchronous active-high reset of the multiplier
//   state    : multiplier FSM state
//   cout     : accumulate adder carry out
// Operands are at most 8 bits, so the 16-bit accumulate can never overflow.
module seq_mult_8x8_cla_chk
    import mult_pkg::*;
(
    input logic   clk,
    input logic   rst,
    input state_e state,
    input logic   cout
);

    a_no_acc_overflow: assert property (
        @(posedge clk) disable iff (rst) (state == RUN) |-> !cout
    );

endmodule

// File: rtl/seq_mult_8x8_cla.sv
// Sequential unsigned 8x8 shift-and-add multiplier, one partial product per
// clock, accumulating through a 16-bit carry-lookahead adder.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   start   : launch request, honoured only in IDLE
//   a, b    : multiplicand / multiplier, latched when start is accepted
//   busy    : high while in RUN or DONE
//   done    : one-cycle pulse when product is updated
//   product : last completed result, held until the next completion
module seq_mult_8x8_cla
    import mult_pkg::*;
#(
    parameter int N     = OP_W,
    parameter int STEPS = OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    state_e              state_q, state_d;
    logic [PROD_W-1:0]   mcand_q, mcand_d;
    logic [N-1:0]        mplier_q, mplier_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PROD_W-1:0]   product_q, product_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [PROD_W-1:0]   addend_s;
    logic [PROD_W-1:0]   sum_s;
    logic                cout_s;

    // Partial product for this step: the shifted multiplicand when the
    // current multiplier LSB is set.
    assign addend_s = mplier_q[0] ? mcand_q : 16'h0000;

    CLA_16_bit_lookahead u_cla (
        .a    (acc_q),
        .b    (addend_s),
        .cin  (1'b0),
        .sum  (sum_s),
        .cout (cout_s)
    );

    seq_mult_8x8_cla_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .state (state_q),
        .cout  (cout_s)
    );

    // Next-state, datapath and output-flag logic.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{(PROD_W-N){1'b0}}, a};
                    mplier_d = b;
                    acc_d    = 16'h0000;
                    count_d  = 4'd0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                acc_d    = sum_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 4'd1;
                if (count_q == 4'(STEPS - 1)) begin
                    product_d = sum_s;
                    state_d   = DONE;
                end else begin
                    state_d   = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Flags are registered from the next state so they line up with it.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= 16'h0000;
            mplier_q  <= 8'h00;
            acc_q     <= 16'h0000;
            count_q   <= 4'd0;
            product_q <= 16'h0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_8x8_cla.sv
// Self-checking bench for seq_mult_8x8_cla: a table of directed operand
// pairs with hand-computed products, plus hand-written sequences for reset,
// held start with changing operands, mid-run reset and reset/start collision.
module tb_seq_mult_8x8_cla;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [9];

    seq_mult_8x8_cla dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete operation launched from IDLE, with exact latency checks.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] exp, input string name);
        logic early;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);                 // edge T: start accepted
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv; // latched copies must be used
        chk({name, " busy after T"}, {31'd0, busy}, 32'd1);
        chk({name, " done after T"}, {31'd0, done}, 32'd0);
        early = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (done) early = 1'b1;
        end
        chk({name, " no early done"}, {31'd0, early}, 32'd0);
        @(negedge clk);                 // after edge T+8
        chk({name, " done pulse"}, {31'd0, done}, 32'd1);
        chk({name, " busy in DONE"}, {31'd0, busy}, 32'd1);
        chk({name, " product"}, {16'd0, product}, {16'd0, exp});
        @(negedge clk);                 // after edge T+9
        chk({name, " done drops"}, {31'd0, done}, 32'd0);
        chk({name, " busy drops"}, {31'd0, busy}, 32'd0);
        chk({name, " product held"}, {16'd0, product}, {16'd0, exp});
    endtask

    initial begin
        logic seen;
        int   wait_cnt;

        vecs[0] = '{8'd13,  8'd11,  16'h008F, "basic_13x11"};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01, "max_255x255"};
        vecs[2] = '{8'd0,   8'd200, 16'h0000, "zero_a"};
        vecs[3] = '{8'd200, 8'd0,   16'h0000, "zero_b"};
        vecs[4] = '{8'd1,   8'd1,   16'h0001, "one_x_one"};
        vecs[5] = '{8'd255, 8'd1,   16'h00FF, "255x1"};
        vecs[6] = '{8'd128, 8'd2,   16'h0100, "128x2"};
        vecs[7] = '{8'd170, 8'd85,  16'h3872, "170x85"};
        vecs[8] = '{8'd1,   8'd255, 16'h00FF, "1x255"};

        rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset product", {16'd0, product}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("idle stays quiet", {31'd0, seen}, 32'd0);

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

        // Start held high; operands change during RUN.
        @(negedge clk);
        a = 8'd6; b = 8'd7; start = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        a = 8'd99; b = 8'd99;
        seen = 1'b0; wait_cnt = 0;
        while (!seen && wait_cnt < 12) begin
            @(negedge clk);
            wait_cnt++;
            if (done) seen = 1'b1;
        end
        chk("held start first done", {31'd0, seen}, 32'd1);
        chk("held start first product", {16'd0, product}, 32'd42);
        seen = 1'b0; wait_cnt = 0;
        while (!seen && wait_cnt < 14) begin
            @(negedge clk);
            wait_cnt++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk("relaunch done", {31'd0, seen}, 32'd1);
        chk("relaunch product", {16'd0, product}, 32'h2649);
        repeat (12) @(negedge clk);
        chk("after relaunch idle", {31'd0, busy}, 32'd0);

        // Mid-run reset: prior product 0x2649 must be cleared.
        @(negedge clk);
        a = 8'd3; b = 8'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun rst busy", {31'd0, busy}, 32'd0);
        chk("midrun rst done", {31'd0, done}, 32'd0);
        chk("midrun rst product", {16'd0, product}, 32'd0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("midrun no done", {31'd0, seen}, 32'd0);
        run_op(8'd3, 8'd5, 16'd15, "after_rst_3x5");

        // Reset and start on the same edge: reset wins.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 8'd9; b = 8'd9;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst+start busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("rst+start not accepted", {31'd0, seen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
